// File: rtl/moldudp64_tx.sv
// moldudp64_tx: MoldUDP64 packet builder.
//
// Purpose:
//   For each accepted command, emits the 20-byte MoldUDP64 header: session id, sequence
//   number and message count, all big-endian. It then emits each message, prefixed by its
//   2-byte length. The bytes are packed onto a 64-bit AXI stream, and the downstream
//   sequence number is tracked across packets. Only AXI_DATA_W = 64 and ML_W = 16 are
//   supported.
//
// Ports:
//   clk, nreset          clock, asynchronous active-low reset
//   sid_i                80-bit session id, byte 0 = sid_i[79:72]; sampled on command accept
//   seq_init_v_i/_i      load the sequence number (honoured only while idle)
//   seq_o                sequence number of the next packet
//   cmd_valid_i/_ready_o packet request handshake; cmd_msg_cnt_i = message count
//                        (0 = heartbeat, 16'hFFFF = end of session)
//   msg_*                message beats: lane 0 first, thermometer keep, length with first beat
//   upd_axis_*           packed AXI stream master towards the UDP stack
//   err_o                1-cycle pulse when a message's byte count differs from its length
module moldudp64_tx #(
  parameter int unsigned AXI_DATA_W = 64,
  parameter int unsigned AXI_KEEP_W = 8,
  parameter int unsigned ML_W       = 16,
  parameter logic [63:0] SEQ_RST    = 64'd1
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic [79:0]           sid_i,
  input  logic                  seq_init_v_i,
  input  logic [63:0]           seq_init_i,
  output logic [63:0]           seq_o,
  input  logic                  cmd_valid_i,
  input  logic [ML_W-1:0]       cmd_msg_cnt_i,
  output logic                  cmd_ready_o,
  input  logic                  msg_valid_i,
  input  logic [AXI_DATA_W-1:0] msg_data_i,
  input  logic [AXI_KEEP_W-1:0] msg_keep_i,
  input  logic                  msg_last_i,
  input  logic [ML_W-1:0]       msg_len_i,
  output logic                  msg_ready_o,
  output logic [AXI_DATA_W-1:0] upd_axis_tdata_o,
  output logic [AXI_KEEP_W-1:0] upd_axis_tkeep_o,
  output logic                  upd_axis_tvalid_o,
  output logic                  upd_axis_tlast_o,
  input  logic                  upd_axis_tready_i,
  output logic                  err_o
);

  typedef enum logic [2:0] {
    StIdle,
    StHdr0,
    StHdr1,
    StHdr2,
    StMlen,
    StMdata,
    StFlush
  } state_e;

  state_e       state_q;
  logic [127:0] buf_q;        // byte k at [8k+7:8k]; bytes at or above fill_q are kept zero
  logic [4:0]   fill_q;
  logic [79:0]  sid_q;
  logic [63:0]  seq_q;
  logic [63:0]  seq_hdr_q;    // sequence number sampled at accept, used in the header
  logic [15:0]  cnt_q;
  logic [15:0]  msgs_left_q;
  logic [15:0]  len_q;
  logic [15:0]  rcvd_q;
  logic         err_q;

  logic [127:0] buf_d;
  logic [127:0] ins;
  logic [4:0]   fill_d;
  logic [4:0]   fill_pop;
  logic [3:0]   n_pop;
  logic [3:0]   n_app;
  logic [3:0]   keep_n;
  logic [63:0]  app_raw;
  logic [63:0]  app_data;
  logic [15:0]  rcvd_sum;
  logic [63:0]  seq_inc;
  logic         can_app;
  logic         hold;
  logic         tvalid;
  logic         pop;
  logic         msg_acc;
  logic         mlen_acc;
  logic         special_cnt;

  always_comb begin
    keep_n = '0;
    for (int k = 0; k < 8; k++) begin
      keep_n = keep_n + {3'b000, msg_keep_i[k]};
    end
    rcvd_sum    = rcvd_q + {12'h000, keep_n};
    special_cnt = (cnt_q == 16'h0000) || (cnt_q == 16'hFFFF);
    seq_inc     = special_cnt ? 64'd0 : {48'h0, cnt_q};
    can_app     = (fill_q <= 5'd8);

    // A full beat that may be the packet's final beat must wait in the buffer. Otherwise a
    // trailing zero-length message could empty it and leave no beat to carry tlast.
    hold   = (state_q == StMdata) && (msgs_left_q == 16'd1) && (rcvd_q >= len_q) &&
             (fill_q == 5'd8);
    tvalid = ((fill_q >= 5'd8) && !hold) || ((state_q == StFlush) && (fill_q != 5'd0));
    pop    = tvalid && upd_axis_tready_i;
    n_pop  = !pop ? 4'd0 : ((fill_q >= 5'd8) ? 4'd8 : fill_q[3:0]);

    msg_ready_o = (state_q == StMdata) && can_app;
    msg_acc     = msg_valid_i && msg_ready_o;
    mlen_acc    = (state_q == StMlen) && msg_valid_i && can_app;

    app_raw = '0;
    n_app   = '0;
    case (state_q)
      StHdr0: if (can_app) begin
        app_raw = {sid_q[23:16], sid_q[31:24], sid_q[39:32], sid_q[47:40],
                   sid_q[55:48], sid_q[63:56], sid_q[71:64], sid_q[79:72]};
        n_app   = 4'd8;
      end
      StHdr1: if (can_app) begin
        app_raw = {seq_hdr_q[23:16], seq_hdr_q[31:24], seq_hdr_q[39:32], seq_hdr_q[47:40],
                   seq_hdr_q[55:48], seq_hdr_q[63:56], sid_q[7:0], sid_q[15:8]};
        n_app   = 4'd8;
      end
      StHdr2: if (can_app) begin
        app_raw = {32'h0, cnt_q[7:0], cnt_q[15:8], seq_hdr_q[7:0], seq_hdr_q[15:8]};
        n_app   = 4'd4;
      end
      StMlen: if (mlen_acc) begin
        app_raw = {48'h0, msg_len_i[7:0], msg_len_i[15:8]};
        n_app   = 4'd2;
      end
      StMdata: if (msg_acc) begin
        app_raw = msg_data_i;
        n_app   = keep_n;
      end
      default: ;
    endcase

    // Lanes beyond the appended count are zeroed to keep the buffer above fill clean.
    for (int k = 0; k < 8; k++) begin
      app_data[8*k +: 8] = (k < int'(n_app)) ? app_raw[8*k +: 8] : 8'h00;
    end

    fill_pop = fill_q - {1'b0, n_pop};
    ins      = {64'h0, app_data} << {fill_pop, 3'b000};
    buf_d    = (pop ? {64'h0, buf_q[127:64]} : buf_q) | ins;
    fill_d   = fill_pop + {1'b0, n_app};
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q     <= StIdle;
      buf_q       <= '0;
      fill_q      <= '0;
      sid_q       <= '0;
      seq_q       <= SEQ_RST;
      seq_hdr_q   <= '0;
      cnt_q       <= '0;
      msgs_left_q <= '0;
      len_q       <= '0;
      rcvd_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      buf_q  <= buf_d;
      fill_q <= fill_d;
      err_q  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (seq_init_v_i) seq_q <= seq_init_i;
          if (cmd_valid_i) begin
            sid_q       <= sid_i;
            cnt_q       <= cmd_msg_cnt_i;
            seq_hdr_q   <= seq_q;
            msgs_left_q <= ((cmd_msg_cnt_i == 16'h0000) || (cmd_msg_cnt_i == 16'hFFFF)) ?
                           16'h0000 : cmd_msg_cnt_i;
            state_q     <= StHdr0;
          end
        end
        StHdr0: if (can_app) state_q <= StHdr1;
        StHdr1: if (can_app) state_q <= StHdr2;
        StHdr2: if (can_app) begin
          if (msgs_left_q != 16'd0) begin
            state_q <= StMlen;
          end else begin
            state_q <= StFlush;
            seq_q   <= seq_q + seq_inc;
          end
        end
        StMlen: if (mlen_acc) begin
          len_q   <= msg_len_i;
          rcvd_q  <= '0;
          state_q <= StMdata;
        end
        StMdata: if (msg_acc) begin
          rcvd_q <= rcvd_sum;
          if (msg_last_i) begin
            err_q       <= (rcvd_sum != len_q);
            msgs_left_q <= msgs_left_q - 16'd1;
            if (msgs_left_q == 16'd1) begin
              state_q <= StFlush;
              seq_q   <= seq_q + seq_inc;
            end else begin
              state_q <= StMlen;
            end
          end
        end
        StFlush: if (pop && (fill_q <= 5'd8)) state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    upd_axis_tdata_o  = buf_q[63:0];
    upd_axis_tvalid_o = tvalid;
    upd_axis_tlast_o  = (state_q == StFlush) && (fill_q <= 5'd8) && (fill_q != 5'd0);
    for (int k = 0; k < 8; k++) begin
      upd_axis_tkeep_o[k] = (k < int'(fill_q));
    end
    cmd_ready_o = (state_q == StIdle);
    seq_o       = seq_q;
    err_o       = err_q;
  end

endmodule

// File: tb/tb_moldudp64_tx.sv
module tb_moldudp64_tx;

  localparam logic [79:0] SID = "SESSION001";

  logic        clk = 1'b0;
  logic        nreset;
  logic [79:0] sid_i;
  logic        seq_init_v_i;
  logic [63:0] seq_init_i;
  logic [63:0] seq_o;
  logic        cmd_valid_i;
  logic [15:0] cmd_msg_cnt_i;
  logic        cmd_ready_o;
  logic        msg_valid_i;
  logic [63:0] msg_data_i;
  logic [7:0]  msg_keep_i;
  logic        msg_last_i;
  logic [15:0] msg_len_i;
  logic        msg_ready_o;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tvalid;
  logic        tlast;
  logic        tready;
  logic        err_o;

  always #5 clk = ~clk;

  moldudp64_tx dut (
    .clk               (clk),
    .nreset            (nreset),
    .sid_i             (sid_i),
    .seq_init_v_i      (seq_init_v_i),
    .seq_init_i        (seq_init_i),
    .seq_o             (seq_o),
    .cmd_valid_i       (cmd_valid_i),
    .cmd_msg_cnt_i     (cmd_msg_cnt_i),
    .cmd_ready_o       (cmd_ready_o),
    .msg_valid_i       (msg_valid_i),
    .msg_data_i        (msg_data_i),
    .msg_keep_i        (msg_keep_i),
    .msg_last_i        (msg_last_i),
    .msg_len_i         (msg_len_i),
    .msg_ready_o       (msg_ready_o),
    .upd_axis_tdata_o  (tdata),
    .upd_axis_tkeep_o  (tkeep),
    .upd_axis_tvalid_o (tvalid),
    .upd_axis_tlast_o  (tlast),
    .upd_axis_tready_i (tready),
    .err_o             (err_o)
  );

  typedef struct {
    logic [15:0] cnt;
    int          nmsg;
    logic [15:0] len0;
    int          nb0;
    logic [7:0]  base0;
    logic [15:0] len1;
    int          nb1;
    logic [7:0]  base1;
    bit          toggle;      // tready 1010...
    bit          init_v;      // seq_init_v_i together with the command
    logic [63:0] init_val;
    int          exp_beats;
    logic [7:0]  exp_keep;    // tkeep of the tlast beat
    logic [63:0] exp_seq;     // seq_o after the packet
    int          exp_err;     // err_o pulses
  } vec_t;

  typedef struct {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    logic [15:0] len;
  } mbeat_t;

  vec_t        vecs[9];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [63:0] model_seq;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    cmd_valid_i   = 1'b0;
    seq_init_v_i  = 1'b0;
    msg_valid_i   = 1'b0;
    msg_data_i    = '0;
    msg_keep_i    = '0;
    msg_last_i    = 1'b0;
    msg_len_i     = '0;
    tready        = 1'b1;
  endtask

  task automatic run_packet(input int vi);
    vec_t        v;
    mbeat_t      mq[$];
    logic [7:0]  exp_b[$];
    logic [7:0]  got_b[$];
    logic [15:0] lens[2];
    int          nbs[2];
    logic [7:0]  bases[2];
    int          cyc, accept_cyc, first_valid, beats, errs, nonff, bad_bytes, nbeats;
    bit          cmd_pend, done, mr_seen, stall_prev;
    logic [63:0] pd;
    logic [7:0]  pk, last_keep;
    logic        pl;
    mbeat_t      mb;

    v = vecs[vi];
    lens[0] = v.len0;  nbs[0] = v.nb0;  bases[0] = v.base0;
    lens[1] = v.len1;  nbs[1] = v.nb1;  bases[1] = v.base1;

    // Expected wire bytes: header, then length-prefixed messages.
    for (int k = 0; k < 10; k++) exp_b.push_back(SID[79-8*k -: 8]);
    for (int k = 0; k < 8; k++) exp_b.push_back(model_seq[63-8*k -: 8]);
    exp_b.push_back(v.cnt[15:8]);
    exp_b.push_back(v.cnt[7:0]);
    for (int m = 0; m < v.nmsg; m++) begin
      exp_b.push_back(lens[m][15:8]);
      exp_b.push_back(lens[m][7:0]);
      for (int j = 0; j < nbs[m]; j++) exp_b.push_back(8'(bases[m] + 8'(j)));
      nbeats = (nbs[m] == 0) ? 1 : (nbs[m] + 7) / 8;
      for (int b = 0; b < nbeats; b++) begin
        mb.d = '0;
        mb.k = '0;
        for (int j = 0; j < 8; j++) begin
          if (8 * b + j < nbs[m]) begin
            mb.d[8*j +: 8] = 8'(bases[m] + 8'(8 * b + j));
            mb.k[j]        = 1'b1;
          end
        end
        mb.l   = (b == nbeats - 1);
        mb.len = lens[m];
        mq.push_back(mb);
      end
    end

    sid_i         = SID;
    cmd_msg_cnt_i = v.cnt;
    seq_init_i    = v.init_val;
    cyc = 0; accept_cyc = -100; first_valid = -1; beats = 0; errs = 0; nonff = 0;
    cmd_pend = 1'b1; done = 1'b0; mr_seen = 1'b0; stall_prev = 1'b0;
    last_keep = '0; pd = '0; pk = '0; pl = 1'b0;

    // Each iteration drives the inputs for the next rising edge and predicts its handshakes.
    while (!done && cyc < 300) begin
      @(negedge clk);
      if (err_o) errs++;
      if (msg_ready_o) mr_seen = 1'b1;
      cmd_valid_i  = cmd_pend;
      seq_init_v_i = cmd_pend && v.init_v;
      if (mq.size() > 0) begin
        msg_valid_i = 1'b1;
        msg_data_i  = mq[0].d;
        msg_keep_i  = mq[0].k;
        msg_last_i  = mq[0].l;
        msg_len_i   = mq[0].len;
      end else begin
        msg_valid_i = 1'b0;
      end
      tready = v.toggle ? (cyc % 2 == 0) : 1'b1;
      if (stall_prev) begin
        check($sformatf("pkt%0d_hold_valid", vi), 64'(tvalid), 64'd1);
        check($sformatf("pkt%0d_hold_data", vi), tdata, pd);
        check($sformatf("pkt%0d_hold_keep_last", vi), {55'h0, tkeep, tlast}, {55'h0, pk, pl});
      end
      if (cmd_pend && cmd_ready_o) begin
        cmd_pend   = 1'b0;
        accept_cyc = cyc;
      end
      if (first_valid < 0 && tvalid) first_valid = cyc;
      if (msg_valid_i && msg_ready_o) void'(mq.pop_front());
      if (tvalid && tready) begin
        beats++;
        for (int j = 0; j < 8; j++) if (tkeep[j]) got_b.push_back(tdata[8*j +: 8]);
        last_keep = tkeep;
        if (tlast) done = 1'b1;
        else if (tkeep != 8'hFF) nonff++;
      end
      stall_prev = tvalid && !tready;
      pd = tdata; pk = tkeep; pl = tlast;
      cyc++;
    end
    idle_inputs();
    repeat (2) begin
      @(negedge clk);
      if (err_o) errs++;
    end

    check($sformatf("pkt%0d_timeout", vi), 64'(done), 64'd1);
    check($sformatf("pkt%0d_latency", vi), 64'(first_valid - accept_cyc), 64'd2);
    check($sformatf("pkt%0d_beats", vi), 64'(beats), 64'(v.exp_beats));
    check($sformatf("pkt%0d_last_keep", vi), 64'(last_keep), 64'(v.exp_keep));
    check($sformatf("pkt%0d_mid_keep", vi), 64'(nonff), 64'd0);
    check($sformatf("pkt%0d_nbytes", vi), 64'(got_b.size()), 64'(exp_b.size()));
    bad_bytes = 0;
    for (int i = 0; i < exp_b.size() && i < got_b.size(); i++) begin
      if (got_b[i] !== exp_b[i]) bad_bytes++;
    end
    check($sformatf("pkt%0d_bad_bytes", vi), 64'(bad_bytes), 64'd0);
    check($sformatf("pkt%0d_seq", vi), seq_o, v.exp_seq);
    check($sformatf("pkt%0d_err_pulses", vi), 64'(errs), 64'(v.exp_err));
    check($sformatf("pkt%0d_idle_ready", vi), {62'h0, cmd_ready_o, tvalid}, 64'b10);
    if (v.cnt == 16'h0000 || v.cnt == 16'hFFFF) begin
      check($sformatf("pkt%0d_msg_ready_seen", vi), 64'(mr_seen), 64'd0);
    end
    model_seq = v.exp_seq;
  endtask

  // Reset while a message is in flight: outputs must clear at once, without a clock edge.
  task automatic reset_mid_message();
    bit seen;
    seen          = 1'b0;
    sid_i         = SID;
    cmd_msg_cnt_i = 16'd1;
    cmd_valid_i   = 1'b1;
    msg_valid_i   = 1'b1;
    msg_data_i    = 64'h0706050403020100;
    msg_keep_i    = 8'hFF;
    msg_last_i    = 1'b0;
    msg_len_i     = 16'd16;
    tready        = 1'b1;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      cmd_valid_i = (c == 0);
      if (msg_ready_o) seen = 1'b1;
    end
    check("rst_reached_mdata", 64'(seen), 64'd1);
    @(negedge clk);
    #2 nreset = 1'b0;
    #1;
    check("rst_tvalid", 64'(tvalid), 64'd0);
    check("rst_cmd_ready", 64'(cmd_ready_o), 64'd1);
    check("rst_msg_ready", 64'(msg_ready_o), 64'd0);
    check("rst_seq", seq_o, 64'd1);
    idle_inputs();
    @(negedge clk);
    nreset = 1'b1;
    model_seq = 64'd1;
  endtask

  initial begin
    // cnt nmsg len0 nb0 base0 len1 nb1 base1 tog init init_val beats keep seq err
    vecs[0] = '{16'h0000, 0, 16'd0, 0, 8'h00, 16'd0, 0, 8'h00, 1'b0, 1'b0, 64'd0,
                3, 8'h0F, 64'd1, 0};
    vecs[1] = '{16'h0001, 1, 16'd5, 5, 8'hAA, 16'd0, 0, 8'h00, 1'b0, 1'b0, 64'd0,
                4, 8'h07, 64'd2, 0};
    // 20 + 10 + 5 = 35 bytes: the final beat carries 3 bytes.
    vecs[2] = '{16'h0002, 2, 16'd8, 8, 8'h10, 16'd3, 3, 8'h20, 1'b1, 1'b0, 64'd0,
                5, 8'h07, 64'd4, 0};
    vecs[3] = '{16'hFFFF, 0, 16'd0, 0, 8'h00, 16'd0, 0, 8'h00, 1'b0, 1'b0, 64'd0,
                3, 8'h0F, 64'd1, 0};
    vecs[4] = '{16'h0001, 1, 16'd6, 4, 8'h30, 16'd0, 0, 8'h00, 1'b0, 1'b0, 64'd0,
                4, 8'h03, 64'd2, 1};
    vecs[5] = '{16'h0001, 1, 16'd0, 0, 8'h00, 16'd0, 0, 8'h00, 1'b0, 1'b0, 64'd0,
                3, 8'h3F, 64'd3, 0};
    // Two empty messages: exactly 24 bytes, so the tlast beat is a full one.
    vecs[6] = '{16'h0002, 2, 16'd0, 0, 8'h00, 16'd0, 0, 8'h00, 1'b0, 1'b0, 64'd0,
                3, 8'hFF, 64'd5, 0};
    vecs[7] = '{16'h0000, 0, 16'd0, 0, 8'h00, 16'd0, 0, 8'h00, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF,
                3, 8'h0F, 64'hFFFF_FFFF_FFFF_FFFF, 0};
    vecs[8] = '{16'h0002, 2, 16'd1, 1, 8'h40, 16'd0, 0, 8'h00, 1'b1, 1'b0, 64'd0,
                4, 8'h01, 64'd1, 0};

    model_seq     = 64'd1;
    nreset        = 1'b0;
    sid_i         = '0;
    seq_init_i    = '0;
    cmd_msg_cnt_i = '0;
    idle_inputs();
    #12;
    @(negedge clk);
    check("reset_cmd_ready", 64'(cmd_ready_o), 64'd1);
    check("reset_seq", seq_o, 64'd1);
    check("reset_outputs", {tdata[55:0], tkeep}, 64'd0);
    check("reset_flags", {60'h0, tvalid, tlast, msg_ready_o, err_o}, 64'd0);
    nreset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      if (i == 3) reset_mid_message();
      run_packet(i);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
